// File: rtl/perm_pkg.sv
// perm_pkg: shared widths, pad constants and pad-framer state type for the perm message front end.
package perm_pkg;
    localparam int SLICE_W     = 200;
    localparam int NSLICE      = 8;
    localparam int SLICE_BYTES = 25;
    localparam logic [7:0] PAD_END   = 8'h80;
    localparam logic [7:0] SHA3_DOM  = 8'h06;
    localparam logic [7:0] SHAKE_DOM = 8'h1F;
    typedef enum logic [1:0] {FILL, EMIT, EMITPAD} pad_state_t;
endpackage

// File: rtl/perm_slice_mux.sv
// perm_slice_mux: selects one 25-byte slice of the 1600-bit block; bytes past the rate read as zero.
module perm_slice_mux import perm_pkg::*; #(
    parameter int RATE_BYTES = 136
) (
    input  logic [NSLICE*SLICE_W-1:0] i_blk,
    input  logic [2:0]                i_ix,
    output logic [SLICE_W-1:0]        o_slice
);
    logic [10:0] w_bit;
    always_comb begin
        o_slice = '0;
        w_bit   = '0;
        for (int j = 0; j < SLICE_BYTES; j++) begin
            w_bit = 11'(200 * i_ix) + 11'(8 * j);
            if (w_bit < 11'(8 * RATE_BYTES)) o_slice[8*j +: 8] = i_blk[w_bit +: 8];
        end
    end
endmodule

// File: rtl/perm_pad_tx.sv
// perm_pad_tx: pads a 64-bit word stream with pad10*1 + domain byte and emits 8-slice rate frames.
// Optional PERM_PAD_DOMAIN_SEL_EN adds i_shake to pick the SHAKE domain byte per message.
module perm_pad_tx import perm_pkg::*; #(
    parameter int         RATE_BYTES = 136,
    parameter logic [7:0] DOMAIN     = SHA3_DOM
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pushin,
    input  logic [63:0]        i_din,
    input  logic [3:0]         i_nbytes,
    input  logic               i_last,
`ifdef PERM_PAD_DOMAIN_SEL_EN
    input  logic               i_shake,
`endif
    output logic               o_stop,
    output logic               o_pushout,
    output logic [2:0]         o_doutix,
    output logic [SLICE_W-1:0] o_dout
);
    localparam int         NW  = RATE_BYTES / 8;
    localparam int         RB  = RATE_BYTES * 8;
    localparam logic [7:0] RB8 = 8'(RATE_BYTES);

    pad_state_t         r_state, w_state_nx;
    logic [RB-1:0]      r_buf, w_buf_nx, w_fill, w_pad;
    logic [4:0]         r_wptr, w_wptr_nx;
    logic [2:0]         r_ix;
    logic               r_padnd, w_padnd_nx;
    logic               w_acc, w_room;
    logic [7:0]         w_p, w_dom, w_pad_dom;
    logic [SLICE_W-1:0] w_slice;

`ifdef PERM_PAD_DOMAIN_SEL_EN
    // Domain is latched at the first word so a whole message (and its pad frame) uses one byte.
    logic       r_in_msg;
    logic [7:0] r_dom;
    assign w_dom     = r_in_msg ? r_dom : (i_shake ? SHAKE_DOM : DOMAIN);
    assign w_pad_dom = r_dom;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_msg <= 1'b0;
            r_dom    <= DOMAIN;
        end else if (w_acc) begin
            r_in_msg <= !i_last;
            r_dom    <= w_dom;
        end
    end
`else
    assign w_dom     = DOMAIN;
    assign w_pad_dom = DOMAIN;
`endif

    assign w_acc  = i_pushin && (r_state == FILL);
    assign w_p    = 8'({r_wptr, 3'b000}) + 8'(i_nbytes);
    assign w_room = i_last && (w_p < RB8);

    always_comb begin
        w_fill = r_buf;
        for (int b = 0; b < RATE_BYTES; b++) begin
            if (5'(b / 8) == r_wptr)
                w_fill[8*b +: 8] = (4'(b % 8) < i_nbytes) ? i_din[8*(b%8) +: 8] : 8'h00;
            if (w_room && 8'(b) == w_p) w_fill[8*b +: 8] = w_fill[8*b +: 8] ^ w_dom;
        end
        if (w_room) w_fill[RB-8 +: 8] = w_fill[RB-8 +: 8] ^ PAD_END;
    end

    always_comb begin
        w_pad            = '0;
        w_pad[7:0]       = w_pad_dom;
        w_pad[RB-8 +: 8] = w_pad[RB-8 +: 8] ^ PAD_END;
    end

    always_comb begin
        w_state_nx = r_state;
        w_buf_nx   = r_buf;
        w_wptr_nx  = r_wptr;
        w_padnd_nx = r_padnd;
        case (r_state)
            FILL: if (w_acc) begin
                w_buf_nx  = w_fill;
                w_wptr_nx = r_wptr + 5'd1;
                if (i_last || r_wptr == 5'(NW - 1)) begin
                    w_state_nx = EMIT;
                    w_padnd_nx = i_last && (w_p == RB8);
                end
            end
            EMIT: if (r_ix == 3'd7) begin
                // A full final block still owes a pad-only frame; stage it in the buffer.
                w_wptr_nx  = '0;
                w_buf_nx   = r_padnd ? w_pad : '0;
                w_state_nx = r_padnd ? EMITPAD : FILL;
                w_padnd_nx = 1'b0;
            end
            EMITPAD: if (r_ix == 3'd7) begin
                w_buf_nx   = '0;
                w_state_nx = FILL;
            end
            default: w_state_nx = FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FILL;
            r_buf   <= '0;
            r_wptr  <= '0;
            r_padnd <= 1'b0;
            r_ix    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_buf   <= w_buf_nx;
            r_wptr  <= w_wptr_nx;
            r_padnd <= w_padnd_nx;
            r_ix    <= (r_state == FILL) ? 3'd0 : r_ix + 3'd1;
        end
    end

    perm_slice_mux #(.RATE_BYTES(RATE_BYTES)) u_mux (
        .i_blk   ((NSLICE*SLICE_W)'(r_buf)),
        .i_ix    (r_ix),
        .o_slice (w_slice)
    );

    assign o_stop    = (r_state != FILL);
    assign o_pushout = (r_state != FILL);
    assign o_doutix  = r_ix;
    assign o_dout    = o_pushout ? w_slice : '0;

    a_nbytes_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_acc |-> (i_nbytes <= 4'd8) && (i_last || i_nbytes == 4'd8));
endmodule

// File: tb/tb_perm_pad_tx.sv
// tb_perm_pad_tx: directed checks of padding, frame timing, pad-only frames, hold-off and mid-frame reset.
module tb_perm_pad_tx;
    logic         clk = 1'b0, rst_n = 1'b0, pushin = 1'b0, last = 1'b0;
    logic [63:0]  din = '0;
    logic [3:0]   nbytes = '0;
    logic         stop, pushout;
    logic [2:0]   doutix;
    logic [199:0] dout;
    int           n_cmp = 0, n_bad = 0;
    logic [7:0]   ef [200];
    logic [199:0] cap [64];
    int           npush, nacc;
    logic         acc_next;

    always #5 clk = ~clk;

    perm_pad_tx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pushin(pushin), .i_din(din), .i_nbytes(nbytes),
        .i_last(last), .o_stop(stop), .o_pushout(pushout), .o_doutix(doutix), .o_dout(dout)
    );

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] eslice(input int s);
        logic [199:0] r;
        for (int j = 0; j < 25; j++) r[8*j +: 8] = ef[25*s + j];
        return r;
    endfunction

    function automatic logic [63:0] wd(input int w);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(8*w + k + 1);
        return r;
    endfunction

    task automatic clr_ef();
        for (int i = 0; i < 200; i++) ef[i] = 8'h00;
    endtask

    task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic l);
        int t = 0;
        while (stop && t < 50) begin @(negedge clk); t++; end
        chk("send_wait_stop", stop, 0);
        din = d; nbytes = nb; last = l; pushin = 1'b1;
        @(negedge clk);
        pushin = 1'b0; last = 1'b0;
    endtask

    task automatic frame(input string name);
        for (int s = 0; s < 8; s++) begin
            chk({name, "_pushout"}, pushout, 1);
            chk({name, "_stop"}, stop, 1);
            chk({name, "_doutix"}, doutix, 200'(s));
            chk($sformatf("%s_slice%0d", name, s), dout, eslice(s));
            @(negedge clk);
        end
    endtask

    task automatic set_abc();
        clr_ef();
        ef[0] = 8'h61; ef[1] = 8'h62; ef[2] = 8'h63; ef[3] = 8'h0a; ef[4] = 8'h06; ef[135] = 8'h80;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pushout", pushout, 0);
        chk("rst_stop", stop, 0);
        chk("rst_doutix", doutix, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc\n": literal slices plus full frame against the byte map
        send(64'h0a636261, 4'd4, 1'b1);
        chk("abc_s0_lit", dout, 200'h60a636261);
        set_abc();
        frame("abc");
        chk("abc_stop_low", stop, 0);

        // zero-length message
        send(64'hdeadbeefcafef00d, 4'd0, 1'b1);
        clr_ef(); ef[0] = 8'h06; ef[135] = 8'h80;
        chk("zero_s0_lit", dout, 200'h06);
        frame("zero");
        chk("zero_stop_low", stop, 0);

        // 136 bytes: data frame, then pad-only frame, stop high for 16 cycles
        for (int w = 0; w < 17; w++) send(wd(w), 4'd8, w == 16);
        clr_ef();
        for (int i = 0; i < 136; i++) ef[i] = 8'(i + 1);
        frame("b136_data");
        clr_ef(); ef[0] = 8'h06; ef[135] = 8'h80;
        frame("b136_pad");
        chk("b136_stop_low", stop, 0);

        // 135 bytes: last byte carries 0x06 ^ 0x80; the masked din byte must not leak
        for (int w = 0; w < 16; w++) send(wd(w), 4'd8, 1'b0);
        send(wd(16), 4'd7, 1'b1);
        clr_ef();
        for (int i = 0; i < 135; i++) ef[i] = 8'(i + 1);
        ef[135] = 8'h86;
        frame("b135");
        chk("b135_stop_low", stop, 0);

        // 139-byte message with the final word held across the first frame
        for (int w = 0; w < 17; w++) send(wd(w), 4'd8, 1'b0);
        din = wd(17); nbytes = 4'd3; last = 1'b1; pushin = 1'b1;
        npush = 0; nacc = 0; acc_next = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (pushout && npush < 64) begin cap[npush] = dout; npush++; end
            if (pushin && !stop) acc_next = 1'b1;
            @(negedge clk);
            if (acc_next) begin pushin = 1'b0; last = 1'b0; acc_next = 1'b0; nacc++; end
        end
        chk("hold_npush", 200'(npush), 200'd16);
        chk("hold_nacc", 200'(nacc), 200'd1);
        clr_ef();
        for (int i = 0; i < 136; i++) ef[i] = 8'(i + 1);
        for (int s = 0; s < 8; s++) chk($sformatf("hold_f1_slice%0d", s), cap[s], eslice(s));
        clr_ef();
        ef[0] = 8'd137; ef[1] = 8'd138; ef[2] = 8'd139; ef[3] = 8'h06; ef[135] = 8'h80;
        for (int s = 0; s < 8; s++) chk($sformatf("hold_f2_slice%0d", s), cap[8+s], eslice(s));

        // reset at doutix=3, then a clean frame
        send(64'h0a636261, 4'd4, 1'b1);
        for (int t = 0; t < 20 && doutix != 3'd3; t++) @(negedge clk);
        chk("rstmid_reach_ix3", doutix, 3);
        rst_n = 1'b0;
        #1;
        chk("rstmid_pushout", pushout, 0);
        chk("rstmid_stop", stop, 0);
        chk("rstmid_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(64'h0a636261, 4'd4, 1'b1);
        set_abc();
        frame("rstmid_abc");
        chk("rstmid_stop_low", stop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
